// File: rtl/divider_sequencer.sv
// Programmable clock divider that steps through a 4-entry {divisor, duration} table,
// holding each divisor for a given number of output periods.
module divider_sequencer #(
    parameter int unsigned WIDTH       = 28,
    parameter int unsigned DEFAULT_DIV = 127551
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [15:0]      cfg_dur,
    output logic             clock_out,
    output logic             busy,
    output logic [1:0]       step_idx,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] div_q [4];
    logic [15:0]      dur_q [4];
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [15:0]      rem_q, rem_d;
    logic [1:0]       step_q, step_d;
    logic             clk_q, clk_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             tbl_we;
    logic             wrap;
    logic             seq_end;
    logic [1:0]       nxt_step;

    function automatic logic [15:0] eff_dur(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        rem_d     = rem_q;
        step_d    = step_q;
        clk_d     = clk_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tbl_we    = 1'b0;

        // cur_div_q is >= 2 whenever wrap is consumed, so the subtraction cannot underflow there
        wrap     = (cnt_q >= cur_div_q - WIDTH'(1));
        nxt_step = step_q + 2'd1;
        seq_end  = (step_q == 2'd3) || (div_q[nxt_step] == '0);

        if (cfg_we) begin
            if (state_q == IDLE && cfg_div != WIDTH'(1)) tbl_we = 1'b1;
            else                                         err_d  = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (start && !stop) begin
                    if (div_q[0] != '0) begin
                        state_d   = RUN;
                        step_d    = 2'd0;
                        cur_div_d = div_q[0];
                        rem_d     = eff_dur(dur_q[0]);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                end else begin
                    clk_d = (cnt_q < (cur_div_q >> 1));
                    cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
                    if (wrap) begin
                        if (rem_q > 16'd1) begin
                            rem_d = rem_q - 16'd1;
                        end else if (!seq_end) begin
                            step_d    = nxt_step;
                            cur_div_d = div_q[nxt_step];
                            rem_d     = eff_dur(dur_q[nxt_step]);
                        end else if (loop) begin
                            step_d    = 2'd0;
                            cur_div_d = div_q[0];
                            rem_d     = eff_dur(dur_q[0]);
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            clk_d   = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_div_q <= '0;
            rem_q     <= '0;
            step_q    <= '0;
            clk_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            div_q[0]  <= WIDTH'(DEFAULT_DIV);
            dur_q[0]  <= 16'd1;
            for (int unsigned i = 1; i < 4; i++) begin
                div_q[i] <= '0;
                dur_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            rem_q     <= rem_d;
            step_q    <= step_d;
            clk_q     <= clk_d;
            done_q    <= done_d;
            err_q     <= err_d;
            if (tbl_we) begin
                div_q[cfg_addr] <= cfg_div;
                dur_q[cfg_addr] <= cfg_dur;
            end
        end
    end

    assign clock_out = clk_q;
    assign busy      = (state_q == RUN);
    assign step_idx  = step_q;
    assign done      = done_q;
    assign cfg_err   = err_q;

endmodule

// File: doc/divider_sequencer.md
DIVIDER_SEQUENCER -- requirements
Module: divider_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 28, divisor and counter width
- DEFAULT_DIV, 127551, divisor of table entry 0 after reset
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock_in, in, 1, sole clock; all logic on posedge
- reset, in, 1, synchronous, active-high
- start, in, 1, start sequence; 1-cycle pulse
- stop, in, 1, abort sequence
- loop, in, 1, restart at step 0 after the last step
- cfg_we, in, 1, table write strobe
- cfg_addr, in, 2, table entry index 0..3
- cfg_div, in, WIDTH, divisor value to write
- cfg_dur, in, 16, step duration in output periods
- clock_out, out, 1, divided clock output (registered)
- busy, out, 1, high while in RUN
- step_idx, out, 2, index of the active step
- done, out, 1, 1-cycle pulse when the sequence ends
- cfg_err, out, 1, 1-cycle pulse when a write is rejected

Function
REQ-003 The block SHALL hold a 4-entry table of {div, dur}; div==0 SHALL mark end-of-sequence.
REQ-004 There SHALL be 2 states: IDLE and RUN.
REQ-005 The block SHALL accept a cfg_we write only in IDLE, with cfg_div==0 or cfg_div>=2; the entry SHALL update on the next edge.
REQ-006 The block SHALL reject a cfg_we write in RUN, or with cfg_div==1: table unchanged; cfg_err=1 for the next cycle.
REQ-007 The block SHALL treat a stored dur==0 as 1.
REQ-008 On start in IDLE, if entry0.div!=0, then next edge: state=RUN, step_idx=0, counter=0, remaining=entry0.dur.
REQ-009 On start in IDLE, if entry0.div==0, then next edge: done=1 and the block stays in IDLE.
REQ-010 The block SHALL ignore start while in RUN.
REQ-011 In RUN, each edge: counter<=(counter>=div-1)?0:counter+1; clock_out<=(counter<div/2), with div/2 as integer division.
- Result: div=4 gives 2 high / 2 low; div=5 gives 2 high / 3 low.
REQ-012 A wrap cycle is one where counter>=div-1; on a wrap cycle with remaining>1, remaining SHALL decrement.
REQ-013 On a wrap cycle with remaining==1, the block SHALL advance in the same edge: step_idx+1, counter=0, div/remaining loaded from the new entry; there SHALL be no idle gap between steps.
REQ-014 Advancing from step 3, or into an entry with div==0, SHALL count as end of sequence.
- loop=1: step_idx=0, entry0 loaded, stay in RUN.
- loop=0: state=IDLE, done=1 for one cycle, clock_out=0.
REQ-015 The block SHALL treat the loop input as sampled only at end of sequence.
REQ-016 On stop in RUN, the next edge SHALL give state=IDLE, clock_out=0, busy=0, and no done pulse.
REQ-017 If stop and start are both high in IDLE, stop SHALL win and the block stays in IDLE.
REQ-018 The table SHALL not change while in RUN; the active div is taken from the table at step entry.
REQ-019 busy SHALL equal (state==RUN).
REQ-020 In IDLE, clock_out SHALL be 0 and counter SHALL be 0.

Reset
REQ-021 reset SHALL take precedence over all inputs, including mid-RUN.
REQ-022 After reset: state=IDLE, clock_out=0, busy=0, done=0, cfg_err=0, step_idx=0, counter=0.
REQ-023 After reset the table SHALL be: entry0={DEFAULT_DIV,1}; entries 1..3={0,0}.

Verification
REQ-024 Write e0={4,2}, e1={0,0}; pulse start -> clock_out 1,1,0,0,1,1,0,0, then done pulse, busy low.
REQ-025 Write e0={5,1}, e1={2,3}, e2={0,0}; start -> pattern 1,1,0,0,0, then 1,0 x3 with no gap; step_idx 0->1; done.
REQ-026 Four entries {2,1}, loop=1, start -> step_idx 0,1,2,3,0 continuously; done never asserts.
REQ-027 cfg_we in RUN, and cfg_we with cfg_div=1 in IDLE -> cfg_err pulse each time; table readback unchanged.
REQ-028 Run e0={10,5}:
- stop at cycle 7 -> next cycle clock_out=0, busy=0, no done.
- start+stop together in IDLE -> stays IDLE.
REQ-029 Assert reset mid-RUN -> next cycle all outputs at reset values; start -> entry0 runs with DEFAULT_DIV.
